// File: rtl/uart_cfg_core.sv
// rtl/uart_cfg_core.sv - UART core: TX/RX FIFOs, 16x oversampled TX/RX FSMs, runtime baud divisor
module uart_cfg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the simultaneous push lands in, so push+pop while full is accepted.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge Clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

module uart_cfg_core #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic [15:0]          baud_div,
    input  logic                 Enable_rx,
    input  logic                 Enable_tx,
    input  logic                 RX,
    input  logic                 rd_uart_en,
    output logic [DATA_BITS-1:0] RX_data,
    output logic                 Empty,
    output logic [CNT_W-1:0]     rx_count,
    input  logic [DATA_BITS-1:0] TX_data,
    input  logic                 wr_uart_en,
    output logic                 Full,
    output logic [CNT_W-1:0]     tx_count,
    output logic                 TX,
    output logic                 Busy,
    output logic                 Overrun,
    output logic                 Frame_error,
    output logic                 Parity_error,
    input  logic                 clr_err
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    // Divisor is only reloaded on wrap so a mid-period change never produces a runt tick.
    logic [15:0] tick_cnt;
    logic [15:0] div_q;
    logic        tick;

    assign tick = (div_q > 16'd1) && (tick_cnt == div_q - 16'd1);

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            tick_cnt <= '0;
            div_q    <= '0;
        end else if (div_q <= 16'd1 || tick) begin
            tick_cnt <= '0;
            div_q    <= baud_div;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    state_t               tx_state;
    logic [4:0]           tx_tcnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_fifo_empty;
    logic                 tx_stop_end;
    logic                 tx_pop;

    assign tx_stop_end = (tx_state == S_STOP) && tick && (tx_tcnt == STOP_LAST);
    assign tx_pop      = Enable_tx && !tx_fifo_empty && ((tx_state == S_IDLE) || tx_stop_end);
    assign Busy        = (tx_state != S_IDLE) || !tx_fifo_empty;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            tx_state <= S_IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            TX       <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= S_START;
            tx_sh    <= tx_head;
            tx_par   <= par_of(tx_head);
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            TX       <= 1'b0;
        end else if (tick) begin
            case (tx_state)
                S_START: begin
                    if (tx_tcnt == 5'd15) begin
                        tx_state <= S_DATA;
                        tx_tcnt  <= '0;
                        TX       <= tx_sh[0];
                    end else begin
                        tx_tcnt <= tx_tcnt + 5'd1;
                    end
                end
                S_DATA: begin
                    if (tx_tcnt == 5'd15) begin
                        tx_tcnt <= '0;
                        if (tx_bit == BIT_LAST) begin
                            if (PARITY != 0) begin
                                tx_state <= S_PARITY;
                                TX       <= tx_par;
                            end else begin
                                tx_state <= S_STOP;
                                TX       <= 1'b1;
                            end
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_sh  <= tx_sh >> 1;
                            TX     <= tx_sh[1];
                        end
                    end else begin
                        tx_tcnt <= tx_tcnt + 5'd1;
                    end
                end
                S_PARITY: begin
                    if (tx_tcnt == 5'd15) begin
                        tx_state <= S_STOP;
                        tx_tcnt  <= '0;
                        TX       <= 1'b1;
                    end else begin
                        tx_tcnt <= tx_tcnt + 5'd1;
                    end
                end
                S_STOP: begin
                    if (tx_tcnt == STOP_LAST) begin
                        tx_state <= S_IDLE;
                        TX       <= 1'b1;
                    end else begin
                        tx_tcnt <= tx_tcnt + 5'd1;
                    end
                end
                default: TX <= 1'b1;
            endcase
        end
    end

    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    state_t               rx_state;
    logic [3:0]           rx_tcnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_perr;
    logic                 rx_fifo_full;
    logic                 rx_stop_done;
    logic                 rx_push;

    assign rx_stop_done = Enable_rx && (rx_state == S_STOP) && tick && (rx_tcnt == 4'd15);
    assign rx_push      = rx_stop_done && !rx_fifo_full;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (!Enable_rx) begin
                rx_state <= S_IDLE;
            end else begin
                case (rx_state)
                    S_IDLE: begin
                        if (rx_prev && !rx_s2) begin
                            rx_state <= S_START;
                            rx_tcnt  <= '0;
                            rx_perr  <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (tick) begin
                            // Mid-start check rejects glitches shorter than half a bit.
                            if (rx_tcnt == 4'd7) begin
                                rx_tcnt <= '0;
                                rx_bit  <= '0;
                                rx_state <= rx_s2 ? S_IDLE : S_DATA;
                            end else begin
                                rx_tcnt <= rx_tcnt + 4'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (tick) begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                            if (rx_tcnt == 4'd15) begin
                                rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                                if (rx_bit == BIT_LAST) rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                                else                    rx_bit   <= rx_bit + 3'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (tick) begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                            if (rx_tcnt == 4'd15) begin
                                rx_perr  <= (rx_s2 != par_of(rx_sh));
                                rx_state <= S_STOP;
                            end
                        end
                    end
                    S_STOP: begin
                        if (tick) begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                            if (rx_tcnt == 4'd15) rx_state <= S_IDLE;
                        end
                    end
                    default: rx_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Overrun      <= 1'b0;
            Frame_error  <= 1'b0;
            Parity_error <= 1'b0;
        end else begin
            if (rx_stop_done && rx_fifo_full) Overrun <= 1'b1;
            else if (clr_err)                 Overrun <= 1'b0;
            if (rx_stop_done && !rx_s2)       Frame_error <= 1'b1;
            else if (clr_err)                 Frame_error <= 1'b0;
            if (rx_stop_done && rx_perr)      Parity_error <= 1'b1;
            else if (clr_err)                 Parity_error <= 1'b0;
        end
    end

    uart_cfg_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .Clk    (Clk),
        .Resetn (Resetn),
        .push   (rx_push),
        .wdata  (rx_sh),
        .pop    (rd_uart_en),
        .rdata  (RX_data),
        .empty  (Empty),
        .full   (rx_fifo_full),
        .count  (rx_count)
    );

    uart_cfg_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .Clk    (Clk),
        .Resetn (Resetn),
        .push   (wr_uart_en),
        .wdata  (TX_data),
        .pop    (tx_pop),
        .rdata  (tx_head),
        .empty  (tx_fifo_empty),
        .full   (Full),
        .count  (tx_count)
    );
endmodule
